boton_leds_ctrl: RTL



---
 rtl/boton_leds_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/boton_leds_ctrl.sv
// Button front end: 2-FF synchroniser, per-channel debounce FSM, press pulse
// generation and an up/down/clear LED counter driven by the press pulses.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_STABLE  | synchronised level equals btn_db, counter idle at 0
// ST_PENDING | level differs from btn_db, counting consecutive differing cycles
module boton_leds_ctrl #(
    parameter int NUM_BTN    = 2,
    parameter int LED_W      = 4,
    parameter int DEB_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] btn_db,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [LED_W-1:0]   leds
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_e;

    logic [NUM_BTN-1:0] s1_q, s2_q;
    logic [NUM_BTN-1:0] db_q, db_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [LED_W-1:0]   leds_q, leds_d;
    deb_state_e         state_q [NUM_BTN];
    deb_state_e         state_d [NUM_BTN];
    logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d   [NUM_BTN];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            press_q <= '0;
            leds_q  <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1_q    <= btn;
            s2_q    <= s1_q;
            db_q    <= db_d;
            press_q <= press_d;
            leds_q  <= leds_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Any return to the old level while pending restarts the whole window.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    if (s2_q[i] != db_q[i]) begin
                        state_d[i] = ST_PENDING;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                ST_PENDING: begin
                    if (s2_q[i] == db_q[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                        db_d[i]    = ~db_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Channels 2 and up act as clear; up and down together cancel out.
    always_comb begin
        logic clr;
        clr = 1'b0;
        for (int k = 2; k < NUM_BTN; k++) begin
            clr = clr | press_q[k];
        end
        press_d = db_d & ~db_q;
        leds_d  = leds_q;
        if (clr) begin
            leds_d = '0;
        end else if (press_q[0] && press_q[1]) begin
            leds_d = leds_q;
        end else if (press_q[0]) begin
            leds_d = leds_q + LED_W'(1);
        end else if (press_q[1]) begin
            leds_d = leds_q - LED_W'(1);
        end
    end

    assign btn_db    = db_q;
    assign btn_press = press_q;
    assign leds      = leds_q;

endmodule
